keyon_gain_ctrl: RTL and testbench

Sits directly downstream of the key debouncer. It consumes that stage's active-low, one-clock KEYON press pulses from three debounced keys (up, down, mute) and maintains a gain setting for the audio datapath. Gain changes are applied as a slow stepwise ramp so the output never jumps by more than one step, which avoids zipper noise. gain_out feeds the audio gain multiplier.

---
 rtl/keyon_gain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_keyon_gain_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyon_gain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keyon_gain_ctrl
//  Brief    : Turns debounced up/down/mute key press pulses into a stored
//             gain setting and a slow one-step-at-a-time ramped output gain
//             that drives the audio gain multiplier without zipper noise.
//  Revision : 1.0  initial release
// ============================================================================
module keyon_gain_ctrl #(
    parameter int GAIN_W     = 4,
    parameter int GAIN_RESET = 8,
    parameter int GAIN_MAX   = 15,
    parameter int RAMP_DIV   = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              keyon_up,
    input  logic              keyon_dn,
    input  logic              keyon_mute,
    output logic [GAIN_W-1:0] gain_target,
    output logic [GAIN_W-1:0] gain_out,
    output logic              mute,
    output logic              ramping,
    output logic              gain_change
);

    // Divider is wide enough to hold RAMP_DIV itself, so RAMP_DIV=1 still works.
    localparam int                 c_DIV_W      = $clog2(RAMP_DIV + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(RAMP_DIV - 1);
    localparam logic [GAIN_W-1:0]  c_GAIN_RESET = GAIN_W'(GAIN_RESET);
    localparam logic [GAIN_W-1:0]  c_GAIN_MAX   = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0]  c_GAIN_ONE   = GAIN_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_STEP = 2'd2;

    // Key bit order: [0]=up, [1]=down, [2]=mute.
    logic [2:0]         w_raw;
    logic [2:0]         r_s1;
    logic [2:0]         r_s2;
    logic [2:0]         r_ev;

    logic [GAIN_W-1:0]  r_gain_target;
    logic               r_mute;
    logic [GAIN_W-1:0]  w_eff_target;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic [GAIN_W-1:0]  r_gain_out;
    logic [GAIN_W-1:0]  w_gain_next;
    logic               w_change_next;
    logic               r_gain_change;
    logic               r_ramping;

    assign w_raw = {keyon_mute, keyon_dn, keyon_up};

    // Two-flop sampling per key; a high-to-low transition is one press event.
    // The event is registered once more, so the stored setting changes on the
    // second posedge after the low level is first sampled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 3'b111;
            r_s2 <= 3'b111;
            r_ev <= 3'b000;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            r_ev <= r_s2 & ~r_s1;
        end
    end

    // Saturating target update and mute toggle; simultaneous up+down cancels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gain_target <= c_GAIN_RESET;
            r_mute        <= 1'b0;
        end else begin
            if (r_ev[0] && !r_ev[1]) begin
                if (r_gain_target < c_GAIN_MAX) begin
                    r_gain_target <= r_gain_target + c_GAIN_ONE;
                end
            end else if (r_ev[1] && !r_ev[0]) begin
                if (r_gain_target != '0) begin
                    r_gain_target <= r_gain_target - c_GAIN_ONE;
                end
            end
            if (r_ev[2]) begin
                r_mute <= ~r_mute;
            end
        end
    end

    assign w_eff_target = r_mute ? '0 : r_gain_target;

    // Ramp state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Ramp next-state: wait RAMP_DIV clocks, take one step, repeat until matched.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_gain_out != w_eff_target) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_div == c_DIV_LAST) begin
                    w_state_next = c_ST_STEP;
                end
            end
            c_ST_STEP: begin
                if (w_gain_next == w_eff_target) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_state_next = c_ST_WAIT;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Ramp datapath: divider, one-step move toward the live target, change flag.
    always_comb begin
        w_div_next    = r_div;
        w_gain_next   = r_gain_out;
        w_change_next = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_div_next = '0;
            end
            c_ST_WAIT: begin
                w_div_next = r_div + c_DIV_W'(1);
            end
            c_ST_STEP: begin
                w_div_next = '0;
                if (r_gain_out < w_eff_target) begin
                    w_gain_next = r_gain_out + c_GAIN_ONE;
                end else if (r_gain_out > w_eff_target) begin
                    w_gain_next = r_gain_out - c_GAIN_ONE;
                end
                w_change_next = (r_gain_out != w_eff_target);
            end
            default: begin
                w_div_next = '0;
            end
        endcase
    end

    // Registered ramp outputs; ramping tracks the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div         <= '0;
            r_gain_out    <= c_GAIN_RESET;
            r_gain_change <= 1'b0;
            r_ramping     <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_gain_out    <= w_gain_next;
            r_gain_change <= w_change_next;
            r_ramping     <= (w_state_next != c_ST_IDLE);
        end
    end

    assign gain_target = r_gain_target;
    assign gain_out    = r_gain_out;
    assign mute        = r_mute;
    assign ramping     = r_ramping;
    assign gain_change = r_gain_change;

endmodule
`default_nettype wire

// File: tb/tb_keyon_gain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keyon_gain_ctrl
//  Brief    : Self-checking bench for keyon_gain_ctrl with a behavioural
//             reference model, directed scenarios and random key presses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keyon_gain_ctrl;

    localparam int GAIN_W     = 4;
    localparam int GAIN_RESET = 8;
    localparam int GAIN_MAX   = 15;
    localparam int RAMP_DIV   = 4;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b1;
    logic              keyon_up   = 1'b1;
    logic              keyon_dn   = 1'b1;
    logic              keyon_mute = 1'b1;
    logic [GAIN_W-1:0] gain_target;
    logic [GAIN_W-1:0] gain_out;
    logic              mute;
    logic              ramping;
    logic              gain_change;

    int n_checks = 0;
    int n_pass   = 0;
    int kcyc     = 0;

    keyon_gain_ctrl #(
        .GAIN_W     (GAIN_W),
        .GAIN_RESET (GAIN_RESET),
        .GAIN_MAX   (GAIN_MAX),
        .RAMP_DIV   (RAMP_DIV)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .keyon_up    (keyon_up),
        .keyon_dn    (keyon_dn),
        .keyon_mute  (keyon_mute),
        .gain_target (gain_target),
        .gain_out    (gain_out),
        .mute        (mute),
        .ramping     (ramping),
        .gain_change (gain_change)
    );

    always #5 clock = ~clock;

    // Reference model: key sample history (newest in bit 0), stored setting,
    // ramped gain, and the absolute cycle at which the next ramp step lands.
    typedef struct packed {
        logic [3:0] target;
        logic [3:0] gain;
        logic       mute;
        logic       ramping;
        logic       pulse;
        int         step_at;
        logic [2:0] hu;
        logic [2:0] hd;
        logic [2:0] hm;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.target  = 4'(GAIN_RESET);
        r.gain    = 4'(GAIN_RESET);
        r.mute    = 1'b0;
        r.ramping = 1'b0;
        r.pulse   = 1'b0;
        r.step_at = 0;
        r.hu      = 3'b111;
        r.hd      = 3'b111;
        r.hm      = 3'b111;
        return r;
    endfunction

    // A press is a sample history of "high then low"; it takes effect two
    // edges after the low sample. A ramp step lands RAMP_DIV+1 edges after
    // the mismatch is noticed or after the previous step.
    function automatic model_t model_next(model_t c, logic up, logic dn, logic mu, int k);
        model_t     n;
        logic [3:0] eff;
        logic       eu, ed, em;
        n   = c;
        eff = c.mute ? 4'd0 : c.target;
        eu  = c.hu[2] & ~c.hu[1];
        ed  = c.hd[2] & ~c.hd[1];
        em  = c.hm[2] & ~c.hm[1];
        n.hu = {c.hu[1:0], up};
        n.hd = {c.hd[1:0], dn};
        n.hm = {c.hm[1:0], mu};
        if (eu && !ed && int'(c.target) < GAIN_MAX) n.target = c.target + 4'd1;
        else if (ed && !eu && c.target != 4'd0)     n.target = c.target - 4'd1;
        if (em) n.mute = ~c.mute;
        n.pulse = 1'b0;
        if (c.ramping) begin
            if (k == c.step_at) begin
                if (c.gain < eff)      n.gain = c.gain + 4'd1;
                else if (c.gain > eff) n.gain = c.gain - 4'd1;
                n.pulse = (c.gain != eff);
                if (n.gain == eff) n.ramping = 1'b0;
                else               n.step_at = k + RAMP_DIV + 1;
            end
        end else if (c.gain != eff) begin
            n.ramping = 1'b1;
            n.step_at = k + RAMP_DIV + 1;
        end
        return n;
    endfunction

    // Advance the model on every clock edge; reset it with the DUT.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_next(m, keyon_up, keyon_dn, keyon_mute, kcyc);
    end

    // Free-running edge counter used by the model's step schedule.
    always @(posedge clock) kcyc <= kcyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("cyc_gain_target", int'(gain_target), int'(m.target));
            chk("cyc_gain_out",    int'(gain_out),    int'(m.gain));
            chk("cyc_mute",        int'(mute),        int'(m.mute));
            chk("cyc_ramping",     int'(ramping),     int'(m.ramping));
            chk("cyc_gain_change", int'(gain_change), int'(m.pulse));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // key: 0=up 1=down 2=mute; held low for 'hold' cycles, then released.
    task automatic press(input int key, input int hold);
        @(negedge clock);
        case (key)
            0:       keyon_up   = 1'b0;
            1:       keyon_dn   = 1'b0;
            default: keyon_mute = 1'b0;
        endcase
        repeat (hold) @(negedge clock);
        keyon_up   = 1'b1;
        keyon_dn   = 1'b1;
        keyon_mute = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        keyon_up   = 1'b1;
        keyon_dn   = 1'b1;
        keyon_mute = 1'b1;
        idle(2);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gain_target"}, int'(gain_target), 8);
        chk({tag, "_gain_out"},    int'(gain_out),    8);
        chk({tag, "_mute"},        int'(mute),        0);
        chk({tag, "_ramping"},     int'(ramping),     0);
        chk({tag, "_gain_change"}, int'(gain_change), 0);
    endtask

    // Wait (bounded) for gain_out to reach v, optionally with the ramp idle.
    task automatic wait_out(input string name, input int v, input bit need_idle, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clock);
            if (int'(gain_out) == v && (!need_idle || !ramping)) hit = 1'b1;
        end
        chk(name, int'(gain_out), v);
    endtask

    initial begin
        // 1: asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1 check_reset_vals("rst_async");
        idle(2);
        reset_n = 1'b1;

        // 2: single up press, exact latency of target and ramp step
        do_reset();
        press(0, 1);                         // low level sampled at edge N
        idle(1);
        chk("t2_target_n1", int'(gain_target), 8);
        idle(1);
        chk("t2_target_n2", int'(gain_target), 9);
        chk("t2_model_target", int'(m.target), 9);
        idle(5);
        chk("t2_out_before", int'(gain_out), 8);
        chk("t2_ramping", int'(ramping), 1);
        idle(1);
        chk("t2_out_after", int'(gain_out), 9);
        chk("t2_model_gain", int'(m.gain), 9);
        chk("t2_pulse", int'(gain_change), 1);
        chk("t2_ramp_done", int'(ramping), 0);
        idle(1);
        chk("t2_pulse_end", int'(gain_change), 0);

        // 3: long hold counts once
        do_reset();
        press(0, 10);
        idle(3);
        chk("t3_target", int'(gain_target), 9);
        idle(20);
        chk("t3_target_late", int'(gain_target), 9);
        chk("t3_out", int'(gain_out), 9);

        // 4: saturation at both ends
        do_reset();
        repeat (10) begin press(0, 1); idle(2); end
        idle(2);
        chk("t4_sat_hi", int'(gain_target), 15);
        wait_out("t4_out_hi", 15, 1'b1, 200);
        repeat (20) begin press(1, 1); idle(2); end
        idle(2);
        chk("t4_sat_lo", int'(gain_target), 0);
        wait_out("t4_out_lo", 0, 1'b1, 200);

        // 5: mute ramps to zero and back
        do_reset();
        press(2, 1);
        idle(2);
        chk("t5_mute", int'(mute), 1);
        idle(40);
        chk("t5_out_1", int'(gain_out), 1);
        idle(1);
        chk("t5_out_0", int'(gain_out), 0);
        chk("t5_model_out_0", int'(m.gain), 0);
        chk("t5_target_kept", int'(gain_target), 8);
        chk("t5_idle", int'(ramping), 0);
        press(2, 1);
        wait_out("t5_out_back", 8, 1'b1, 100);
        chk("t5_unmute", int'(mute), 0);

        // 6: simultaneous up+down, reversal mid-ramp, reset mid-ramp
        do_reset();
        @(negedge clock);
        keyon_up = 1'b0;
        keyon_dn = 1'b0;
        @(negedge clock);
        keyon_up = 1'b1;
        keyon_dn = 1'b1;
        idle(5);
        chk("t6_both", int'(gain_target), 8);
        press(2, 1);
        wait_out("t6_mid", 4, 1'b0, 100);
        press(1, 1);
        idle(2);
        press(2, 1);
        wait_out("t6_reversed", 7, 1'b1, 100);
        chk("t6_target", int'(gain_target), 7);
        press(0, 1);
        idle(5);
        chk("t6_midramp", int'(ramping), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("t6_rst");
        idle(2);
        reset_n = 1'b1;

        // Random key activity against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clock);
                keyon_up = 1'b0;
                keyon_dn = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                keyon_up = 1'b1;
                keyon_dn = 1'b1;
            end else begin
                press(int'($urandom_range(0, 2)), int'($urandom_range(1, 4)));
            end
            idle(int'($urandom_range(0, 12)));
        end
        idle(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
